alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand and result width in bits.
REQ-002 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low.
REQ-004 reqX_valid  input  1  Requester X (X=0,1) presents an operation.
REQ-005 reqX_ready  output  1  Operation from requester X is accepted this cycle.
REQ-006 reqX_a, reqX_b  input  N  Operands A and B from requester X.
REQ-007 reqX_ctrl  input  4  ALU control code from requester X.
REQ-008 reqX_setflags  input  1  Requester X's result updates the shared flag register.
REQ-009 rspX_valid  output  1  Response for requester X is available.
REQ-010 rspX_ready  input  1  Requester X consumes its response.
REQ-011 rsp_result  output  N  Registered ALU result; valid while either rspX_valid is high.
REQ-012 rsp_nzcv  output  4  Registered ALU NZCV for that result.
REQ-013 alu_a, alu_b  output  N  Operands driven to the shared ALU.
REQ-014 alu_ctrl  output  4  Control code driven to the shared ALU.
REQ-015 alu_result  input  N  Combinational result from the ALU.
REQ-016 alu_nzcv  input  4  Combinational NZCV from the ALU.
REQ-017 flags  output  4  Architectural NZCV register.
REQ-018 busy  output  1  High in every state other than IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-020 In IDLE with any reqX_valid high, the FSM SHALL select one winner, assert only that reqX_ready combinationally in the same cycle, latch a, b, ctrl, setflags and the winner ID, and move to EXEC.
REQ-021 reqX_ready SHALL be low in EXEC and RESP and for the losing requester.
REQ-022 In EXEC, alu_a, alu_b and alu_ctrl SHALL be driven from the latched operands, and alu_result and alu_nzcv SHALL be captured into the response registers, followed by a move to RESP.
REQ-023 In IDLE and RESP, alu_a, alu_b and alu_ctrl SHALL be driven to zero.
REQ-024 In EXEC, if the latched setflags is 1, flags SHALL load alu_nzcv at the end of the cycle; otherwise flags SHALL hold.
REQ-025 In RESP, rspX_valid SHALL be high only for the winner and SHALL hold, with result and NZCV stable, until rspX_ready is high.
REQ-026 The handshake cycle SHALL return the FSM to IDLE, with no new acceptance in that cycle.
REQ-027 Latency: acceptance at cycle T SHALL give rspX_valid at T+2; minimum issue interval is 3 cycles.
REQ-028 rspX_ready while rspX_valid is low SHALL be ignored.
REQ-029 Operands, result and flags SHALL pass unmodified; the arbiter performs no arithmetic.
REQ-030 With both requesters valid in the same IDLE cycle, the arbitration rule of REQ-035/REQ-036 SHALL decide the winner.
REQ-031 The non-granted request SHALL be served on a later IDLE cycle if it is still valid.

Reset
REQ-032 While rst_n is low, the block SHALL force state=IDLE, all ready/valid outputs 0, busy 0, rsp_result 0, rsp_nzcv 0, flags 0, ALU outputs 0, and the round-robin pointer to requester 0.
REQ-033 Reset asserted in EXEC or RESP SHALL drop the in-flight operation with no response and no flag update.
REQ-034 The first acceptance SHALL be possible in the first rising edge after rst_n deasserts.

Configuration
REQ-035 With macro ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: the pointer names the preferred requester and moves to the other requester after each grant.
REQ-036 Without ALU_ARB_RR_EN, arbitration SHALL be fixed priority, with requester 0 always winning ties and no pointer register present.

Structure
REQ-037 Package alu_arb_pkg SHALL hold the state enum (IDLE, EXEC, RESP), a 4-bit ALU control typedef with named op constants, and the NZCV bit-index constants N=3, Z=2, C=1, V=0.
REQ-038 Sub-module arb2 SHALL be the only sub-module, as a 2-way arbiter containing the round-robin pointer, selected by ALU_ARB_RR_EN.

Verification
REQ-039 A bench SHALL drive req0 alone with a=5, b=3, ADD op, setflags=1 and check ready at T, rsp0_valid at T+2, rsp_result=8 and flags=0000.
REQ-040 A bench SHALL drive req1 with a=3, b=5, SUB op, setflags=0, starting from flags=0000, and check rsp_result=32'hFFFFFFFE, rsp_nzcv N=1, flags unchanged at 0000.
REQ-041 A bench SHALL keep both requesters continuously valid with RR enabled and check grants alternate 0,1,0,1; without the macro it SHALL check grants 0,0,0.
REQ-042 A bench SHALL hold rsp0_ready low for 5 cycles and check rsp0_valid and the result stable, no new ready, and busy=1 throughout.
REQ-043 A bench SHALL pulse rst_n low during EXEC and check no rspX_valid, flags=0, state IDLE, and next acceptance at the first edge after release.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the two-requester ALU arbiter.
//   state_t     - arbiter FSM states (IDLE, EXEC, RESP)
//   alu_ctrl_t  - 4-bit ALU control code, with named operation constants
//   NZCV_*      - bit positions of the N, Z, C and V flags in a 4-bit NZCV word
// The flag indices carry an NZCV_ prefix so that they cannot collide with the
// width parameter N used by the modules that import this package.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = 4'h0;
    localparam alu_ctrl_t ALU_SUB = 4'h1;
    localparam alu_ctrl_t ALU_AND = 4'h2;
    localparam alu_ctrl_t ALU_ORR = 4'h3;
    localparam alu_ctrl_t ALU_EOR = 4'h4;
    localparam alu_ctrl_t ALU_MOV = 4'h5;

    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

endpackage

// File: rtl/alu_arbiter_arb2.sv
// arb2: 2-way request arbiter used by alu_arbiter.
// Build option: ALU_ARB_RR_EN selects round-robin (a pointer names the
// preferred requester and moves to the other requester after each grant).
// Without it, requester 0 has fixed priority and no pointer exists.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_req0, i_req1    requests
//   i_en              grants may be issued this cycle
//   o_gnt0, o_gnt1    one-hot grant (both low when i_en is low)
//   o_id              id of the requester that would win
module arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_en,
    output logic o_gnt0,
    output logic o_gnt1,
    output logic o_id
);

    logic w_id;

`ifdef ALU_ARB_RR_EN
    logic r_ptr;

    always_comb begin
        if (i_req0 && i_req1) begin
            w_id = r_ptr;
        end else begin
            w_id = ~i_req0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_en && (i_req0 || i_req1)) begin
            r_ptr <= ~w_id;
        end
    end
`else
    // Fixed priority is stateless; clock and reset are intentionally unused.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;

    assign w_id = ~i_req0;
`endif

    assign o_gnt0 = i_en && i_req0 && !w_id;
    assign o_gnt1 = i_en && i_req1 && w_id;
    assign o_id   = w_id;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// IDLE accepts one request (ready is combinational), EXEC drives the ALU and
// captures its result, RESP holds the response until the winner consumes it.
// Build option: ALU_ARB_RR_EN (round-robin arbitration instead of fixed
// priority to requester 0), handled inside arb2.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqX_valid/ready/a/b/ctrl/setflags  request channel of requester X
//   rspX_valid/ready                 response handshake of requester X
//   rsp_result, rsp_nzcv             registered ALU result and NZCV
//   alu_a, alu_b, alu_ctrl           operands to the shared ALU (zero unless EXEC)
//   alu_result, alu_nzcv             combinational ALU outputs
//   flags                            architectural NZCV register
//   busy                             high outside IDLE
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_ctrl,
    input  logic         req0_setflags,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_ctrl,
    input  logic         req1_setflags,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp_result,
    output logic [3:0]   rsp_nzcv,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_nzcv,
    output logic [3:0]   flags,
    output logic         busy
);

    state_t     r_state, w_state_d;
    logic [N-1:0] r_a, r_b, r_result;
    alu_ctrl_t  r_ctrl;
    logic       r_setflags, r_id;
    logic [3:0] r_nzcv, r_flags;

    logic w_en, w_gnt0, w_gnt1, w_win_id, w_accept, w_rsp_hs;

    // Gating with rst_n keeps ready low while reset is held.
    assign w_en = (r_state == IDLE) && rst_n;

    arb2 u_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req0 (req0_valid),
        .i_req1 (req1_valid),
        .i_en   (w_en),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1),
        .o_id   (w_win_id)
    );

    assign w_accept = w_gnt0 || w_gnt1;
    assign w_rsp_hs = (r_state == RESP) && (r_id ? rsp1_ready : rsp0_ready);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_d = EXEC;
            EXEC:    w_state_d = RESP;
            RESP:    if (w_rsp_hs) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_ctrl     <= '0;
            r_setflags <= 1'b0;
            r_id       <= 1'b0;
            r_result   <= '0;
            r_nzcv     <= '0;
            r_flags    <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_a        <= w_win_id ? req1_a : req0_a;
                r_b        <= w_win_id ? req1_b : req0_b;
                r_ctrl     <= w_win_id ? req1_ctrl : req0_ctrl;
                r_setflags <= w_win_id ? req1_setflags : req0_setflags;
                r_id       <= w_win_id;
            end
            if (r_state == EXEC) begin
                r_result <= alu_result;
                r_nzcv   <= alu_nzcv;
                if (r_setflags) begin
                    r_flags <= alu_nzcv;
                end
            end
        end
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (r_state == EXEC) begin
            alu_a    = r_a;
            alu_b    = r_b;
            alu_ctrl = r_ctrl;
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp0_valid = (r_state == RESP) && !r_id;
    assign rsp1_valid = (r_state == RESP) && r_id;
    assign rsp_result = r_result;
    assign rsp_nzcv   = r_nzcv;
    assign flags      = r_flags;
    assign busy       = (r_state != IDLE);

endmodule
